// File: rtl/hdmi_period_tracker_if.sv
// hdmi_period_tracker_if
// Groups the character inputs and the period-classification outputs of
// hdmi_period_tracker into one bundle.
//   ch1_data, ch2_data : aligned 10-bit TMDS characters, channels 1 and 2
//   ch0_is_terc4       : channel 0 TERC4 flag, one character later than ch1/ch2
//   in_island          : current character is data-island payload
//   pkt_start          : pulse on character 0 of each packet
//   char_idx           : payload character index within the packet
//   in_video           : current character is active video
//   island_err         : pulse on a data-island protocol violation
//   err_count          : saturating island error count (zero unless enabled)
// Modports: master drives characters and observes outputs; slave is the tracker.
interface hdmi_period_tracker_if;
  logic [9:0]  ch1_data;
  logic [9:0]  ch2_data;
  logic        ch0_is_terc4;
  logic        in_island;
  logic        pkt_start;
  logic [4:0]  char_idx;
  logic        in_video;
  logic        island_err;
  logic [15:0] err_count;

  modport master (
    output ch1_data, ch2_data, ch0_is_terc4,
    input  in_island, pkt_start, char_idx, in_video, island_err, err_count
  );

  modport slave (
    input  ch1_data, ch2_data, ch0_is_terc4,
    output in_island, pkt_start, char_idx, in_video, island_err, err_count
  );
endinterface

// File: rtl/hdmi_period_tracker.sv
// hdmi_period_tracker
// Classifies each HDMI character period as control, data-island guard or
// payload, video guard or active video, using channel 0's TERC4 flag and the
// characters of channels 1 and 2. Outputs are registered and describe the
// character that appeared on ch1_data two clocks earlier.
// Ports:
//   clk_1x_in : pixel-rate character clock
//   rst_n_in  : asynchronous active-low reset
//   link      : hdmi_period_tracker_if.slave (characters in, classification out)
// Optional feature: define HDMI_PERIOD_ERRCNT_EN to build the saturating
// island error counter on err_count; otherwise err_count is tied to zero.
module hdmi_period_tracker #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int PKT_LEN      = 32,
  parameter int MAX_PKTS     = 18
) (
  input logic                  clk_1x_in,
  input logic                  rst_n_in,
  hdmi_period_tracker_if.slave link
);
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int GW = $clog2(GUARD_LEN + 1);
  localparam int KW = $clog2(MAX_PKTS + 1);

  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] CTL1 = 10'b0010101011;
  localparam logic [9:0] CTL2 = 10'b0101010100;
  localparam logic [9:0] CTL3 = 10'b1010101011;
  localparam logic [9:0] GB   = 10'b0100110011;

  typedef enum logic [2:0] {
    CONTROL, LEAD_GUARD, ISLAND, TRAIL_GUARD, VIDEO_GUARD, VIDEO
  } stateT;

  stateT         r_state, w_stateNext;
  logic [9:0]    r_ch1, r_ch2;
  logic [PW-1:0] r_preCnt, w_preCntNext, w_preSat;
  logic          r_preVideo, w_preVideoNext;
  logic [GW-1:0] r_gCnt, w_gCntNext, w_gInc;
  logic [4:0]    r_idx, w_idxNext;
  logic [KW-1:0] r_pktCnt, w_pktCntNext;
  logic          r_inIsland, w_inIsland;
  logic          r_pktStart, w_pktStart;
  logic [4:0]    r_charIdx, w_charIdx;
  logic          r_inVideo, w_inVideo;
  logic          r_err, w_err;
  logic          w_isDiPre, w_isVidPre, w_isGbBoth, w_ch1Gb, w_ch1Ctl, w_preFull;

  assign w_isDiPre  = (r_ch1 == CTL1) && (r_ch2 == CTL1);
  assign w_isVidPre = (r_ch1 == CTL1) && (r_ch2 == CTL0);
  assign w_isGbBoth = (r_ch1 == GB) && (r_ch2 == GB);
  assign w_ch1Gb    = (r_ch1 == GB);
  assign w_ch1Ctl   = (r_ch1 == CTL0) || (r_ch1 == CTL1) ||
                      (r_ch1 == CTL2) || (r_ch1 == CTL3);
  assign w_preFull  = (r_preCnt >= PW'(PREAMBLE_LEN));
  assign w_preSat   = w_preFull ? r_preCnt : r_preCnt + 1'b1;
  assign w_gInc     = r_gCnt + 1'b1;

  // ch1/ch2 are delayed one clock so they line up with the late TERC4 flag.
  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ch1 <= '0;
      r_ch2 <= '0;
    end else begin
      r_ch1 <= link.ch1_data;
      r_ch2 <= link.ch2_data;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= CONTROL;
      r_preCnt   <= '0;
      r_preVideo <= 1'b0;
      r_gCnt     <= '0;
      r_idx      <= '0;
      r_pktCnt   <= '0;
      r_inIsland <= 1'b0;
      r_pktStart <= 1'b0;
      r_charIdx  <= '0;
      r_inVideo  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_preCnt   <= w_preCntNext;
      r_preVideo <= w_preVideoNext;
      r_gCnt     <= w_gCntNext;
      r_idx      <= w_idxNext;
      r_pktCnt   <= w_pktCntNext;
      r_inIsland <= w_inIsland;
      r_pktStart <= w_pktStart;
      r_charIdx  <= w_charIdx;
      r_inVideo  <= w_inVideo;
      r_err      <= w_err;
    end
  end

  // Next-state and output decode. The preamble run length is tracked in every
  // state; r_idx is the index the current character takes if it is payload,
  // and r_idx==0 with packets already seen marks a packet boundary.
  always_comb begin
    w_stateNext    = r_state;
    w_gCntNext     = r_gCnt;
    w_idxNext      = r_idx;
    w_pktCntNext   = r_pktCnt;
    w_preVideoNext = r_preVideo;
    w_preCntNext   = '0;
    w_inIsland     = 1'b0;
    w_pktStart     = 1'b0;
    w_charIdx      = '0;
    w_inVideo      = 1'b0;
    w_err          = 1'b0;

    if (w_isDiPre) begin
      w_preVideoNext = 1'b0;
      w_preCntNext   = (!r_preVideo && r_preCnt != '0) ? w_preSat : PW'(1);
    end else if (w_isVidPre) begin
      w_preVideoNext = 1'b1;
      w_preCntNext   = (r_preVideo && r_preCnt != '0) ? w_preSat : PW'(1);
    end

    case (r_state)
      CONTROL: begin
        if (!r_preVideo && w_preFull && w_isGbBoth && link.ch0_is_terc4) begin
          w_gCntNext   = GW'(1);
          w_idxNext    = '0;
          w_pktCntNext = '0;
          w_stateNext  = (GUARD_LEN == 1) ? ISLAND : LEAD_GUARD;
        end else if (r_preVideo && w_preFull && w_ch1Gb) begin
          w_gCntNext  = GW'(1);
          w_stateNext = (GUARD_LEN == 1) ? VIDEO : VIDEO_GUARD;
        end
      end
      LEAD_GUARD: begin
        if (w_isGbBoth && link.ch0_is_terc4) begin
          w_gCntNext = w_gInc;
          if (w_gInc == GW'(GUARD_LEN)) begin
            w_stateNext  = ISLAND;
            w_idxNext    = '0;
            w_pktCntNext = '0;
          end
        end else begin
          w_err        = 1'b1;
          w_preCntNext = '0;
          w_stateNext  = CONTROL;
        end
      end
      ISLAND: begin
        // A dropped TERC4 flag wins over any boundary decision.
        if (!link.ch0_is_terc4) begin
          w_err        = 1'b1;
          w_preCntNext = '0;
          w_stateNext  = CONTROL;
        end else if (r_idx == '0 && r_pktCnt != '0 && w_isGbBoth) begin
          w_gCntNext  = GW'(1);
          w_stateNext = (GUARD_LEN == 1) ? CONTROL : TRAIL_GUARD;
        end else if (r_idx == '0 && r_pktCnt == KW'(MAX_PKTS)) begin
          w_err        = 1'b1;
          w_preCntNext = '0;
          w_stateNext  = CONTROL;
        end else begin
          w_inIsland = 1'b1;
          w_pktStart = (r_idx == '0);
          w_charIdx  = r_idx;
          if (r_idx == '0) w_pktCntNext = r_pktCnt + 1'b1;
          w_idxNext = (r_idx == 5'(PKT_LEN - 1)) ? '0 : r_idx + 1'b1;
        end
      end
      TRAIL_GUARD: begin
        if (w_isGbBoth) begin
          w_gCntNext = w_gInc;
          if (w_gInc == GW'(GUARD_LEN)) w_stateNext = CONTROL;
        end else begin
          w_err        = 1'b1;
          w_preCntNext = '0;
          w_stateNext  = CONTROL;
        end
      end
      VIDEO_GUARD: begin
        if (w_ch1Gb) begin
          w_gCntNext = w_gInc;
          if (w_gInc == GW'(GUARD_LEN)) w_stateNext = VIDEO;
        end else begin
          w_stateNext = CONTROL;
        end
      end
      VIDEO: begin
        if (w_ch1Ctl) w_stateNext = CONTROL;
        else          w_inVideo   = 1'b1;
      end
      default: w_stateNext = CONTROL;
    endcase
  end

  assign link.in_island  = r_inIsland;
  assign link.pkt_start  = r_pktStart;
  assign link.char_idx   = r_charIdx;
  assign link.in_video   = r_inVideo;
  assign link.island_err = r_err;

`ifdef HDMI_PERIOD_ERRCNT_EN
  logic [15:0] r_errCount;

  // Counts on the same edge that raises island_err, holding at all-ones.
  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in)                               r_errCount <= '0;
    else if (w_err && r_errCount != 16'hFFFF)    r_errCount <= r_errCount + 16'd1;
  end

  assign link.err_count = r_errCount;
`else
  assign link.err_count = '0;
`endif
endmodule
